fetch_stage: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the toothless core, succeeding the combinational fetch path of the single-cycle stage. Issues pipelined requests to an instruction memory with a req/gnt/rvalid protocol and variable latency, buffers returned words with their PCs in a FIFO_DEPTH-entry prefetch FIFO, and hands them to decode with a valid/ready handshake. A redirect (jump, branch, trap) flushes buffered and in-flight fetches and restarts fetch at a new address.

---
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: instruction-memory req/gnt/rvalid bus, redirect, decode handshake.
// Latency: none (wires only).
// Backpressure: carries gnt (memory side) and instr_ready_i (decode side) back to the fetch stage.
// Ports: master = fetch stage (drives req/addr, valid/instr/pc/level);
//        slave  = environment (drives gnt/rvalid/rdata, redirect, ready).
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  // instruction memory
  logic                   instr_req_o;
  logic [ADDR_WIDTH-1:0]  instr_addr_o;
  logic                   instr_gnt_i;
  logic                   instr_rvalid_i;
  logic [INSTR_WIDTH-1:0] instr_rdata_i;
  // control flow
  logic                   redirect_i;
  logic [ADDR_WIDTH-1:0]  redirect_addr_i;
  // decode
  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0]  instr_pc_o;
  logic [LW-1:0]          level_o;

  modport master (
    output instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o, level_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_addr_i,
           instr_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o, level_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_addr_i,
           instr_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Decoupled instruction fetch: pipelined req/gnt/rvalid requests into a FIFO_DEPTH prefetch FIFO.
// Latency: response in cycle t is presented to decode in cycle t+1 (registered FIFO).
// Backpressure: requests issue only while buffered + in-flight < FIFO_DEPTH; decode stalls via ready.
// Ports: clk, rst_n (async, active-low); bus (fetch_stage_if.master) carries the memory
//        request/response channel, redirect_i/redirect_addr_i, and the decode valid/ready output.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic                  run_q,        run_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q,     rsp_pc_d;
  logic [CW-1:0]         outst_q,      outst_d;
  logic [CW-1:0]         discard_q,    discard_d;
  logic [CW-1:0]         count_q,      count_d;
  logic [PW-1:0]         wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,     rd_ptr_d;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];

  logic                  credit, req, grant, push, pop, valid;
  logic [CW:0]           inflight;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  unused_redirect_lsbs;

  // The low address bits of a redirect target are forced to zero (word aligned fetch).
  assign redirect_addr        = {bus.redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_addr_i[1:0];

  // In-flight requests include responses still to be discarded, so credit is conservative
  // and the FIFO always has room for every response that will be kept.
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};
  assign credit   = inflight < (CW+1)'(FIFO_DEPTH);

  // Credit only grows while a request waits for its grant, so req/addr stay stable
  // until granted; only a redirect can withdraw a pending request.
  assign req   = run_q & credit & ~bus.redirect_i;
  assign grant = req & bus.instr_gnt_i;
  assign valid = (count_q != '0) & ~bus.redirect_i;
  assign pop   = valid & bus.instr_ready_i;
  assign push  = bus.instr_rvalid_i & ~bus.redirect_i & (discard_q == '0);

  always_comb begin
    run_d        = 1'b1;
    fetch_addr_d = fetch_addr_q;
    rsp_pc_d     = rsp_pc_q;
    outst_d      = outst_q + CW'(grant) - CW'(bus.instr_rvalid_i);
    discard_d    = discard_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;

    if (bus.redirect_i) begin
      fetch_addr_d = redirect_addr;
      rsp_pc_d     = redirect_addr;
      // Everything still in flight is stale. The in-flight count already covers any
      // discards pending from an earlier redirect, so it replaces the discard count
      // rather than adding to it. A response arriving this cycle is dropped here.
      discard_d    = outst_q - CW'(bus.instr_rvalid_i);
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end else begin
      if (grant) begin
        fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
      end
      if (bus.instr_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        fifo_d[wr_ptr_q].instr = bus.instr_rdata_i;
        fifo_d[wr_ptr_q].pc    = rsp_pc_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
        rsp_pc_d               = rsp_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      fetch_addr_q <= BOOT_ADDR;
      rsp_pc_q     <= BOOT_ADDR;
      outst_q      <= '0;
      discard_q    <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_q       <= '{default: '0};
    end else begin
      run_q        <= run_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_pc_q     <= rsp_pc_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q       <= fifo_d;
    end
  end

  // Head is read straight from storage; storage resets to zero so instr_o/instr_pc_o are 0 in reset.
  assign bus.instr_req_o   = req;
  assign bus.instr_addr_o  = fetch_addr_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = fifo_q[rd_ptr_q].instr;
  assign bus.instr_pc_o    = fifo_q[rd_ptr_q].pc;
  assign bus.level_o       = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, directed scenarios, scoreboard monitor.
module tb_fetch_stage;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) fif ();

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .FIFO_DEPTH (DEPTH),
    .BOOT_ADDR  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (fif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          pop_cnt = 0;

  task automatic expect_run(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, mem_data(pc)});
    end
  endtask

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && fif.instr_valid_o && fif.instr_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h instr %h, no output expected",
                   fif.instr_pc_o, fif.instr_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc_instr", {fif.instr_pc_o, fif.instr_o}, e);
        end
      end
    end
  end

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          mcyc       = 0;
  int          last_due   = 0;
  int          grant_cnt  = 0;
  int          gnt_mode   = 0;   // 0 always grant, 1 pattern, 2 budget
  int          gnt_budget = 0;
  int          lat_mode   = 0;   // 0 latency 1, 1 latency pattern
  bit          hold       = 0;
  logic [15:0] gnt_pat    = 16'b1011_0110_1101_0111;
  int          lat_pat[8] = '{1, 3, 5, 2, 4, 1, 5, 2};
  bit          stall_prev = 0;
  logic [31:0] stall_addr = '0;

  initial begin
    bit    g;
    pend_t p;
    fif.instr_gnt_i    = 1'b0;
    fif.instr_rvalid_i = 1'b0;
    fif.instr_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst_n !== 1'b1) begin
        pend.delete();
        fif.instr_gnt_i    = 1'b0;
        fif.instr_rvalid_i = 1'b0;
        stall_prev         = 0;
        last_due           = 0;
        continue;
      end
      if (!hold && pend.size() > 0 && pend[0].due <= mcyc) begin
        p                  = pend.pop_front();
        fif.instr_rvalid_i = 1'b1;
        fif.instr_rdata_i  = mem_data(p.addr);
      end else begin
        fif.instr_rvalid_i = 1'b0;
        fif.instr_rdata_i  = 32'hDEAD_BEEF;
      end
      case (gnt_mode)
        0:       g = 1'b1;
        1:       g = gnt_pat[mcyc % 16];
        default: g = (gnt_budget > 0);
      endcase
      fif.instr_gnt_i = g;
      if (stall_prev && !fif.redirect_i)
        check("req_addr_hold", {31'b0, fif.instr_req_o, fif.instr_addr_o}, {31'b0, 1'b1, stall_addr});
      stall_prev = fif.instr_req_o && !g;
      stall_addr = fif.instr_addr_o;
      if (fif.instr_req_o && g) begin
        p.addr = fif.instr_addr_o;
        p.due  = mcyc + ((lat_mode != 0) ? lat_pat[grant_cnt % 8] : 1);
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend.push_back(p);
        grant_cnt++;
        if (gnt_mode == 2) gnt_budget--;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] rdy_pat = 8'b1101_1110;

  initial begin
    int p0;
    rst_n               = 1'b1;
    fif.redirect_i      = 1'b0;
    fif.redirect_addr_i = '0;
    fif.instr_ready_i   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req",   fif.instr_req_o,   1'b0);
    check("rst_addr",  fif.instr_addr_o,  32'h0);
    check("rst_valid", fif.instr_valid_o, 1'b0);
    check("rst_instr", fif.instr_o,       32'h0);
    check("rst_pc",    fif.instr_pc_o,    32'h0);
    check("rst_level", fif.level_o,       3'd0);

    // S1: streaming from boot, zero-wait grant, latency 1, decode always ready
    step(2);
    fif.instr_ready_i = 1'b1;
    expect_run(32'h0, 10);
    rst_n = 1'b1;                                  // cycle 0
    check("c0_req",   fif.instr_req_o,   1'b0);
    check("c0_valid", fif.instr_valid_o, 1'b0);
    step;                                          // cycle 1
    check("c1_req",  fif.instr_req_o,  1'b1);
    check("c1_addr", fif.instr_addr_o, 32'h0);
    step;                                          // cycle 2
    check("c2_valid", fif.instr_valid_o, 1'b0);
    check("c2_addr",  fif.instr_addr_o,  32'h4);
    step;                                          // cycle 3
    check("c3_valid", fif.instr_valid_o, 1'b1);
    step(10);                                      // cycle 13
    fif.instr_ready_i = 1'b0;
    check("s1_pops", pop_cnt, 10);

    // S2: decode stalled, credit caps requests at FIFO_DEPTH
    step(10);
    check("s2_grants", grant_cnt,       14);
    check("s2_level",  fif.level_o,     3'd4);
    check("s2_req",    fif.instr_req_o, 1'b0);
    expect_run(32'h28, 1);
    fif.instr_ready_i = 1'b1;
    step;
    fif.instr_ready_i = 1'b0;
    step(6);
    check("s2_one_more_grant", grant_cnt,       15);
    check("s2_refill_level",   fif.level_o,     3'd4);
    check("s2_req_again_low",  fif.instr_req_o, 1'b0);
    check("s2_pops",           pop_cnt,         11);

    // S3: grant stalls, 1-5 cycle latency, intermittent ready
    p0 = pop_cnt;
    expect_run(32'h2C, 80);
    gnt_mode = 1;
    lat_mode = 1;
    for (int i = 0; i < 80; i++) begin
      fif.instr_ready_i = rdy_pat[i % 8];
      step;
    end
    check("s3_progress", (pop_cnt - p0) >= 20, 1'b1);

    // S4: redirect with 2 buffered and 2 outstanding
    fif.instr_ready_i   = 1'b0;
    gnt_mode            = 2;
    gnt_budget          = 0;
    lat_mode            = 0;
    fif.redirect_i      = 1'b1;
    fif.redirect_addr_i = 32'h200;
    exp_q.delete();
    step;
    fif.redirect_i = 1'b0;
    step(10);
    check("s4_flushed_level", fif.level_o, 3'd0);
    gnt_budget = 2;
    step(6);
    check("s4_buffered", fif.level_o, 3'd2);
    hold       = 1;
    gnt_budget = 2;
    step(4);
    check("s4_no_credit", fif.instr_req_o, 1'b0);
    fif.redirect_i      = 1'b1;
    fif.redirect_addr_i = 32'h100;
    exp_q.delete();
    expect_run(32'h100, 16);
    #1;
    check("s4_redirect_valid", fif.instr_valid_o, 1'b0);
    step;
    fif.redirect_i    = 1'b0;
    gnt_mode          = 0;
    hold              = 0;
    fif.instr_ready_i = 1'b1;
    #1;
    check("s4_level_cleared", fif.level_o,      3'd0);
    check("s4_req_new",       fif.instr_req_o,  1'b1);
    check("s4_addr_new",      fif.instr_addr_o, 32'h100);
    p0 = pop_cnt;
    step(16);
    check("s4_progress", (pop_cnt - p0) >= 5, 1'b1);

    // S5: redirect coinciding with a response and decode ready; unaligned target
    fif.redirect_i      = 1'b1;
    fif.redirect_addr_i = 32'h103;
    exp_q.delete();
    expect_run(32'h100, 16);
    #1;
    check("s5_redirect_valid", fif.instr_valid_o, 1'b0);
    check("s5_redirect_req",   fif.instr_req_o,   1'b0);
    step;
    fif.redirect_i = 1'b0;
    #1;
    check("s5_req",   fif.instr_req_o,  1'b1);
    check("s5_addr",  fif.instr_addr_o, 32'h100);
    check("s5_level", fif.level_o,      3'd0);
    p0 = pop_cnt;
    step(10);
    check("s5_progress", (pop_cnt - p0) >= 5, 1'b1);

    // S6: address wrap, then asynchronous reset mid-burst
    fif.redirect_i      = 1'b1;
    fif.redirect_addr_i = 32'hFFFF_FFF8;
    exp_q.delete();
    expect_run(32'hFFFF_FFF8, 16);
    step;
    fif.redirect_i = 1'b0;
    #1;
    check("s6_addr0", fif.instr_addr_o, 32'hFFFF_FFF8);
    step;
    check("s6_addr1", fif.instr_addr_o, 32'hFFFF_FFFC);
    step;
    check("s6_addr_wrap", fif.instr_addr_o, 32'h0000_0000);
    p0 = pop_cnt;
    step(6);
    check("s6_progress", (pop_cnt - p0) >= 4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",   fif.instr_req_o,   1'b0);
    check("arst_addr",  fif.instr_addr_o,  32'h0);
    check("arst_valid", fif.instr_valid_o, 1'b0);
    check("arst_instr", fif.instr_o,       32'h0);
    check("arst_pc",    fif.instr_pc_o,    32'h0);
    check("arst_level", fif.level_o,       3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
